// File: rtl/vga_axil_pkg.sv
// Shared types and helpers for the VGA AXI-lite to native register bridge:
// response codes, FSM state encodings and the byte-to-word address mapping.
package vga_axil_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } axil_resp_t;

   typedef enum logic [2:0] {
      W_IDLE,
      W_GOT_ADDR,
      W_GOT_DATA,
      W_ISSUE,
      W_RESP
   } w_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ISSUE,
      R_WAIT,
      R_RESP
   } r_state_t;

   // Untruncated word address; callers cut it down to the native width.
   function automatic logic [63:0] axil2native_addr(input logic [63:0] addr, input int unsigned data_w);
      return addr >> $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/vga_axil_if.sv
// AXI-lite bundle between the interconnect and the VGA bridge. The clk/arst_n
// ports belong to the bus side; the bridge runs on its own clk/rst.
interface vga_axil_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic clk,
   input logic arst_n
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      input  clk, arst_n,
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/vga_axil_rd_delay.sv
// Delays the native read strobe by LATENCY cycles; the output marks the cycle
// in which rd_data_i is valid and must be sampled.
module vga_axil_rd_delay #(
   parameter int LATENCY = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe_in,
   output logic strobe_out
);
   logic [LATENCY-1:0] pipe;

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe <= '0;
      end else begin
         pipe[0] <= strobe_in;
         for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign strobe_out = pipe[LATENCY-1];
endmodule

// File: rtl/vga_axil_slave_native.sv
// AXI-lite slave to native register/RAM port bridge with independent write and
// read FSMs. Optional decode errors: define VGA_AXIL_DECERR_EN.
//
// state      | meaning
// W_IDLE     | waiting for AW and/or W
// W_GOT_ADDR | AW captured, waiting for W
// W_GOT_DATA | W captured, waiting for AW
// W_ISSUE    | native write pulse (suppressed on decode error)
// W_RESP     | bvalid held until bready
// R_IDLE     | waiting for AR
// R_ISSUE    | native read pulse (suppressed on decode error)
// R_WAIT     | waiting READ_LATENCY cycles for rd_data_i
// R_RESP     | rvalid held until rready
module vga_axil_slave_native
   import vga_axil_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int ADDR_W        = 32,
   parameter int NATIVE_ADDR_W = 8,
   parameter int NUM_WORDS     = 256,
   parameter int READ_LATENCY  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   vga_axil_if.slave                axil_if,
   output logic                     wr_en_o,
   output logic [NATIVE_ADDR_W-1:0] wr_addr_o,
   output logic [DATA_W-1:0]        wr_data_o,
   output logic [DATA_W/8-1:0]      wr_strb_o,
   output logic                     rd_en_o,
   output logic [NATIVE_ADDR_W-1:0] rd_addr_o,
   input  logic [DATA_W-1:0]        rd_data_i
);
   w_state_t   w_state, w_next;
   r_state_t   r_state, r_next;
   logic       awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
   logic       awready_d, wready_d, bvalid_d, arready_d, rvalid_d, wr_en_d, rd_en_d;
   axil_resp_t bresp_q, bresp_d, rresp_q, rresp_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic       aw_err_now, ar_err_now, aw_err_q, ar_err_q, aw_err_eff;
   logic       rd_sample;
   logic [NATIVE_ADDR_W-1:0] aw_word_now, ar_word_now;

   assign aw_hs = axil_if.awvalid & awready_q;
   assign w_hs  = axil_if.wvalid  & wready_q;
   assign b_hs  = axil_if.bready  & bvalid_q;
   assign ar_hs = axil_if.arvalid & arready_q;
   assign r_hs  = axil_if.rready  & rvalid_q;

   assign aw_word_now = NATIVE_ADDR_W'(axil2native_addr(64'(axil_if.awaddr), DATA_W));
   assign ar_word_now = NATIVE_ADDR_W'(axil2native_addr(64'(axil_if.araddr), DATA_W));

`ifdef VGA_AXIL_DECERR_EN
   assign aw_err_now = axil2native_addr(64'(axil_if.awaddr), DATA_W) >= 64'(NUM_WORDS);
   assign ar_err_now = axil2native_addr(64'(axil_if.araddr), DATA_W) >= 64'(NUM_WORDS);
`else
   assign aw_err_now = 1'b0;
   assign ar_err_now = 1'b0;
`endif

   assign aw_err_eff = aw_hs ? aw_err_now : aw_err_q;

   vga_axil_rd_delay #(.LATENCY(READ_LATENCY)) u_rd_delay (
      .clk        (clk),
      .rst        (rst),
      .strobe_in  (rd_en_o),
      .strobe_out (rd_sample)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state   <= W_IDLE;
         r_state   <= R_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
         rresp_q   <= OKAY;
         rdata_q   <= '0;
         wr_en_o   <= 1'b0;
         rd_en_o   <= 1'b0;
         wr_addr_o <= '0;
         wr_data_o <= '0;
         wr_strb_o <= '0;
         rd_addr_o <= '0;
         aw_err_q  <= 1'b0;
         ar_err_q  <= 1'b0;
      end else begin
         w_state   <= w_next;
         r_state   <= r_next;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         bresp_q   <= bresp_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         wr_en_o   <= wr_en_d;
         rd_en_o   <= rd_en_d;
         if (aw_hs) begin
            wr_addr_o <= aw_word_now;
            aw_err_q  <= aw_err_now;
         end
         if (w_hs) begin
            wr_data_o <= axil_if.wdata;
            wr_strb_o <= axil_if.wstrb;
         end
         if (ar_hs) begin
            rd_addr_o <= ar_word_now;
            ar_err_q  <= ar_err_now;
         end
      end
   end

   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) w_next = W_ISSUE;
            else if (aw_hs)    w_next = W_GOT_ADDR;
            else if (w_hs)     w_next = W_GOT_DATA;
         end
         W_GOT_ADDR: if (w_hs)  w_next = W_ISSUE;
         W_GOT_DATA: if (aw_hs) w_next = W_ISSUE;
         W_ISSUE:               w_next = W_RESP;
         W_RESP:     if (b_hs)  w_next = W_IDLE;
         default:               w_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE:  if (ar_hs)     r_next = R_ISSUE;
         R_ISSUE:                r_next = ar_err_q ? R_RESP : R_WAIT;
         R_WAIT:  if (rd_sample) r_next = R_RESP;
         R_RESP:  if (r_hs)      r_next = R_IDLE;
         default:                r_next = R_IDLE;
      endcase
   end

   // Outputs are computed from the next state and registered above.
   always_comb begin
      awready_d = (w_next == W_IDLE) || (w_next == W_GOT_DATA);
      wready_d  = (w_next == W_IDLE) || (w_next == W_GOT_ADDR);
      bvalid_d  = (w_next == W_RESP);
      wr_en_d   = (w_next == W_ISSUE) && !aw_err_eff;
      bresp_d   = bresp_q;
      if (w_state == W_ISSUE) bresp_d = aw_err_q ? SLVERR : OKAY;

      arready_d = (r_next == R_IDLE);
      rvalid_d  = (r_next == R_RESP);
      rd_en_d   = (r_state == R_IDLE) && ar_hs && !ar_err_now;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      if (r_state == R_WAIT && rd_sample) begin
         rdata_d = rd_data_i;
         rresp_d = OKAY;
      end else if (r_state == R_ISSUE && ar_err_q) begin
         rdata_d = '0;
         rresp_d = SLVERR;
      end
   end

   assign axil_if.awready = awready_q;
   assign axil_if.wready  = wready_q;
   assign axil_if.bvalid  = bvalid_q;
   assign axil_if.bresp   = bresp_q;
   assign axil_if.arready = arready_q;
   assign axil_if.rvalid  = rvalid_q;
   assign axil_if.rresp   = rresp_q;
   assign axil_if.rdata   = rdata_q;
endmodule
